tcp_tx_engine: RTL and testbench
================================

# tcp_tx_engine

Transmit-side session engine sitting between the application and the TCP offload stack's tx interface, clocked on the stack clock `clk`. Accepts per-session send commands of arbitrary byte length and splits each into segments of at most `MAX_SEG_BYTES`. For every segment it issues tx metadata, waits for tx status, and retries after a back-off when the stack has no buffer space. It forwards exactly the segment's data beats with regenerated `keep`/`last`, and reports one completion per command.

## Interface
Parameters:
- `MAX_SEG_BYTES`, 1408: maximum segment payload in bytes; must be a nonzero multiple of 64 and ≤ 65535.
- `RETRY_DELAY`, 256: back-off cycles after a "no space" status; ≥ 1.

Ports:
- `clk`  in  1  stack clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `s_cmd_valid` / `s_cmd_ready`  in / out  1 / 1  command handshake.
- `s_cmd_data`  in  48  command: [15:0] session, [47:16] total bytes.
- `s_data_valid` / `s_data_ready`  in / out  1 / 1  app payload handshake.
- `s_data_data`  in  512  app payload; `s_data_keep`/`s_data_last` are ignored.
- `m_meta_valid` / `m_meta_ready`  out / in  1 / 1  tx metadata handshake.
- `m_meta_data`  out  32  [15:0] session, [31:16] segment length.
- `s_status_valid` / `s_status_ready`  in / out  1 / 1  tx status handshake.
- `s_status_data`  in  64  [15:0] session, [31:16] length, [61:32] remaining space, [63:62] error.
- `m_data_valid` / `m_data_ready`  out / in  1 / 1  payload-to-stack handshake.
- `m_data_data`  out  512  payload to stack.
- `m_data_keep`  out  64  byte enables.
- `m_data_last`  out  1  end of segment.
- `m_done_valid` / `m_done_ready`  out / in  1 / 1  completion handshake.
- `m_done_data`  out  64  [15:0] session, [47:16] bytes sent, [49:48] final error, [63:50] zero.
- `retry_cnt` / `drop_cnt` / `mismatch_cnt`  out  32 each  status counters.

## Operation
- States: IDLE, META, WAIT_ST, BACKOFF, DATA, DRAIN, DONE.
- IDLE:
  - `s_cmd_ready`=1; on accept, latch session, `remaining` = total, `sent` = 0.
  - If total = 0, go to DONE with error 0. Otherwise go to META.
- META:
  - `seg` = min(`remaining`, `MAX_SEG_BYTES`), 16 bits; `m_meta_valid`=1 with {`seg`, session}.
  - On accept, go to WAIT_ST.
- WAIT_ST: `s_status_ready`=1; on accept, act on the error field:
  - 0: go to DATA.
  - 2 (no space): `retry_cnt`++; go to BACKOFF.
  - 1 or 3: `drop_cnt`++; latch the error; go to DRAIN.
  - If the status session or length differs from the pending segment, `mismatch_cnt`++. The error field is still acted on as above.
- BACKOFF: count `RETRY_DELAY` cycles, then go to META with the same `seg` (data not yet consumed).
- DATA:
  - Pass-through: `m_data_valid`=`s_data_valid`, `s_data_ready`=`m_data_ready`, `m_data_data`=`s_data_data`.
  - Beats per segment = ceil(`seg`/64).
  - Non-final beats: keep = all ones. Final beat: keep = low (`seg` mod 64) bits set, or all ones if the mod is 0. `m_data_last`=1 on the final beat only.
  - After the final beat transfers: `sent` += `seg`, `remaining` -= `seg`. Go to DONE if `remaining` = 0, else META.
- DRAIN:
  - `s_data_ready`=1, `m_data_valid`=0; consume ceil(`remaining`/64) beats and discard them.
  - Then go to DONE with the latched error. `sent` excludes the failed segment.
- DONE: `m_done_valid`=1 with {error, `sent`, session}; on accept, go to IDLE.
- `remaining` and `sent` are 32-bit; beat counter is 26-bit. Counters saturate at 2^32-1.

## Timing
- Reset values: all `valid`/`ready` outputs 0, `m_meta_data`/`m_done_data`/`m_data_keep` 0, `m_data_last` 0, counters 0, state IDLE.
- Reset mid-operation abandons the command. No completion is emitted and counters clear.
- `m_meta_valid` rises the cycle after command accept or BACKOFF expiry.
- `m_meta_data` and `m_done_data` are registered and stable while `valid` is high and `ready` is low.
- After a status with error 2 is accepted in cycle T, `m_meta_valid` re-asserts in cycle T+`RETRY_DELAY`+1.
- DATA adds zero latency and no bubbles: with continuous valid/ready, one beat transfers per cycle.
- `m_meta_valid` is asserted in the cycle after the last beat of a non-final segment.
- `s_data_ready`=0 outside DATA/DRAIN. `s_status_ready`=0 outside WAIT_ST. `s_cmd_ready`=0 outside IDLE.
- A status arriving outside WAIT_ST is not accepted; it is held by the source.

## Test plan
- Cmd {sess 0x0005, 100 B}, status err 0:
  - meta 0x00640005.
  - 2 beats: second has keep 0x0000000FFFFFFFFF and last=1.
  - done {sess 5, sent 100, err 0}.
- Cmd 3000 B, MAX 1408, all status ok:
  - metas 1408, 1408, 184.
  - beats 22/22/3, last on beats 22, 44, 47.
  - final keep 0x00FFFFFFFFFFFFFF; done sent 3000.
- First status err 2, then 0:
  - `retry_cnt`=1; second meta identical, `RETRY_DELAY`+1 cycles after the status.
  - no data beats consumed before the second status.
- 3000 B, second status err 1:
  - 22 beats forwarded, then 25 beats drained with `m_data_valid` never high.
  - done {sent 1408, err 1}; `drop_cnt`=1.
- Cmd length 0: no meta issued; done {sent 0, err 0} on the cycle after accept.
- Random throttling of `s_data_valid`, `m_data_ready`, `m_meta_ready` over 10 commands: byte-exact output and correct last/keep.
  - Status session mismatch increments `mismatch_cnt` only.
  - `rstn` low mid-DATA returns all outputs to reset values in the next cycle.

Source files
------------

// File: rtl/tcp_tx_engine.sv
// rtl/tcp_tx_engine.sv - per-session tx segmenter with status retry and payload forwarding
//
// Splits each send command into segments of at most MAX_SEG_BYTES, issues tx
// metadata per segment, waits for tx status and backs off on "no space", then
// forwards exactly that segment's payload beats with regenerated keep/last.
// One completion is reported per command.
//
// Ports:
//   clk, rstn                   clock, synchronous active-low reset
//   s_cmd_*    (48b)            command in: [15:0] session, [47:16] total bytes
//   s_data_*   (512b)           app payload in
//   m_meta_*   (32b)            tx metadata out: [15:0] session, [31:16] seg length
//   s_status_* (64b)            tx status in: [15:0] session, [31:16] length, [63:62] error
//   m_data_*   (512b/64b/1b)    payload out with keep/last
//   m_done_*   (64b)            completion out: [15:0] session, [47:16] sent, [49:48] error
//   retry_cnt/drop_cnt/mismatch_cnt  saturating status counters
module tcp_tx_engine #(
  parameter int MAX_SEG_BYTES = 1408,
  parameter int RETRY_DELAY   = 256
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_cmd_valid,
  output logic         s_cmd_ready,
  input  logic [47:0]  s_cmd_data,
  input  logic         s_data_valid,
  output logic         s_data_ready,
  input  logic [511:0] s_data_data,
  output logic         m_meta_valid,
  input  logic         m_meta_ready,
  output logic [31:0]  m_meta_data,
  input  logic         s_status_valid,
  output logic         s_status_ready,
  input  logic [63:0]  s_status_data,
  output logic         m_data_valid,
  input  logic         m_data_ready,
  output logic [511:0] m_data_data,
  output logic [63:0]  m_data_keep,
  output logic         m_data_last,
  output logic         m_done_valid,
  input  logic         m_done_ready,
  output logic [63:0]  m_done_data,
  output logic [31:0]  retry_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  mismatch_cnt
);

  localparam logic [31:0] MAX32 = 32'(MAX_SEG_BYTES);
  localparam logic [31:0] BO_INIT = 32'(RETRY_DELAY - 1);

  typedef enum logic [2:0] {IDLE, META, WAIT_ST, BACKOFF, DATA, DRAIN, DONE} state_t;

  state_t      state;
  logic [15:0] session;
  logic [15:0] seg;
  logic [31:0] remaining;
  logic [31:0] sent;
  logic [25:0] beat_cnt;
  logic [31:0] bo_cnt;
  logic [1:0]  err;

  function automatic logic [15:0] seg_for(input logic [31:0] rem);
    return (rem < MAX32) ? rem[15:0] : MAX32[15:0];
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Index of the final beat: ceil(n/64)-1 == (n-1)>>6 for n >= 1.
  logic [15:0] seg_m1;
  logic [31:0] rem_m1;
  logic [25:0] seg_last_idx;
  logic [25:0] drain_last_idx;
  logic        is_last_beat;
  logic [63:0] last_keep;
  logic        data_fire;
  logic        drain_fire;
  logic [31:0] rem_after;
  logic [31:0] sent_after;
  logic [15:0] cmd_seg;
  logic [15:0] next_seg;
  logic [1:0]  st_err;
  logic        st_mismatch;
  logic        unused_bits;

  assign seg_m1         = seg - 16'd1;
  assign rem_m1         = remaining - 32'd1;
  assign seg_last_idx   = {16'b0, seg_m1[15:6]};
  assign drain_last_idx = rem_m1[31:6];
  assign is_last_beat   = (beat_cnt == seg_last_idx);
  assign last_keep      = (seg[5:0] == 6'd0) ? '1 : ((64'd1 << seg[5:0]) - 64'd1);
  assign rem_after      = remaining - {16'b0, seg};
  assign sent_after     = sent + {16'b0, seg};
  assign cmd_seg        = seg_for(s_cmd_data[47:16]);
  assign next_seg       = seg_for(rem_after);
  assign st_err         = s_status_data[63:62];
  assign st_mismatch    = (s_status_data[15:0] != session) || (s_status_data[31:16] != seg);
  assign unused_bits    = ^{s_status_data[61:32], seg_m1[5:0], rem_m1[5:0]};

  // Payload path is combinational so DATA adds no latency or bubbles.
  assign m_data_valid = (state == DATA) && s_data_valid;
  assign s_data_ready = ((state == DATA) && m_data_ready) || (state == DRAIN);
  assign m_data_data  = s_data_data;
  assign m_data_last  = (state == DATA) && is_last_beat;
  assign m_data_keep  = (state != DATA) ? '0 : (is_last_beat ? last_keep : '1);
  assign data_fire    = (state == DATA) && s_data_valid && m_data_ready;
  assign drain_fire   = (state == DRAIN) && s_data_valid;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      session        <= '0;
      seg            <= '0;
      remaining      <= '0;
      sent           <= '0;
      beat_cnt       <= '0;
      bo_cnt         <= '0;
      err            <= '0;
      s_cmd_ready    <= 1'b0;
      m_meta_valid   <= 1'b0;
      m_meta_data    <= '0;
      s_status_ready <= 1'b0;
      m_done_valid   <= 1'b0;
      m_done_data    <= '0;
      retry_cnt      <= '0;
      drop_cnt       <= '0;
      mismatch_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          s_cmd_ready <= 1'b1;
          if (s_cmd_valid && s_cmd_ready) begin
            s_cmd_ready <= 1'b0;
            session     <= s_cmd_data[15:0];
            remaining   <= s_cmd_data[47:16];
            sent        <= '0;
            err         <= '0;
            if (s_cmd_data[47:16] == 32'd0) begin
              state        <= DONE;
              m_done_valid <= 1'b1;
              m_done_data  <= {16'b0, 32'b0, s_cmd_data[15:0]};
            end else begin
              state        <= META;
              seg          <= cmd_seg;
              m_meta_valid <= 1'b1;
              m_meta_data  <= {cmd_seg, s_cmd_data[15:0]};
            end
          end
        end
        META: begin
          if (m_meta_ready) begin
            m_meta_valid   <= 1'b0;
            s_status_ready <= 1'b1;
            state          <= WAIT_ST;
          end
        end
        WAIT_ST: begin
          if (s_status_valid) begin
            s_status_ready <= 1'b0;
            beat_cnt       <= '0;
            if (st_mismatch) mismatch_cnt <= sat_inc(mismatch_cnt);
            case (st_err)
              2'd0: state <= DATA;
              2'd2: begin
                retry_cnt <= sat_inc(retry_cnt);
                bo_cnt    <= BO_INIT;
                state     <= BACKOFF;
              end
              default: begin
                drop_cnt <= sat_inc(drop_cnt);
                err      <= st_err;
                state    <= DRAIN;
              end
            endcase
          end
        end
        BACKOFF: begin
          // m_meta_data still holds the pending segment, so it is reissued unchanged.
          if (bo_cnt == 32'd0) begin
            m_meta_valid <= 1'b1;
            state        <= META;
          end else begin
            bo_cnt <= bo_cnt - 32'd1;
          end
        end
        DATA: begin
          if (data_fire) begin
            if (is_last_beat) begin
              beat_cnt  <= '0;
              sent      <= sent_after;
              remaining <= rem_after;
              if (rem_after == 32'd0) begin
                state        <= DONE;
                m_done_valid <= 1'b1;
                m_done_data  <= {14'b0, err, sent_after, session};
              end else begin
                state        <= META;
                seg          <= next_seg;
                m_meta_valid <= 1'b1;
                m_meta_data  <= {next_seg, session};
              end
            end else begin
              beat_cnt <= beat_cnt + 26'd1;
            end
          end
        end
        DRAIN: begin
          // Discards the failed segment and everything after it.
          if (drain_fire) begin
            if (beat_cnt == drain_last_idx) begin
              state        <= DONE;
              m_done_valid <= 1'b1;
              m_done_data  <= {14'b0, err, sent, session};
            end else begin
              beat_cnt <= beat_cnt + 26'd1;
            end
          end
        end
        DONE: begin
          if (m_done_ready) begin
            m_done_valid <= 1'b0;
            s_cmd_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_engine.sv
// tb/tb_tcp_tx_engine.sv - scoreboard bench for tcp_tx_engine
module tb_tcp_tx_engine;

  localparam int MAXB = 1408;
  localparam int RD   = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         s_cmd_valid = 1'b0;
  logic         s_cmd_ready;
  logic [47:0]  s_cmd_data = '0;
  logic         s_data_valid = 1'b0;
  logic         s_data_ready;
  logic [511:0] s_data_data = '0;
  logic         m_meta_valid;
  logic         m_meta_ready = 1'b1;
  logic [31:0]  m_meta_data;
  logic         s_status_valid = 1'b0;
  logic         s_status_ready;
  logic [63:0]  s_status_data = '0;
  logic         m_data_valid;
  logic         m_data_ready = 1'b1;
  logic [511:0] m_data_data;
  logic [63:0]  m_data_keep;
  logic         m_data_last;
  logic         m_done_valid;
  logic         m_done_ready = 1'b1;
  logic [63:0]  m_done_data;
  logic [31:0]  retry_cnt, drop_cnt, mismatch_cnt;

  tcp_tx_engine #(.MAX_SEG_BYTES(MAXB), .RETRY_DELAY(RD)) dut (
    .clk(clk), .rstn(rstn),
    .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_data(s_cmd_data),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_data(s_data_data),
    .m_meta_valid(m_meta_valid), .m_meta_ready(m_meta_ready), .m_meta_data(m_meta_data),
    .s_status_valid(s_status_valid), .s_status_ready(s_status_ready), .s_status_data(s_status_data),
    .m_data_valid(m_data_valid), .m_data_ready(m_data_ready), .m_data_data(m_data_data),
    .m_data_keep(m_data_keep), .m_data_last(m_data_last),
    .m_done_valid(m_done_valid), .m_done_ready(m_done_ready), .m_done_data(m_done_data),
    .retry_cnt(retry_cnt), .drop_cnt(drop_cnt), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { logic [511:0] d; logic [63:0] k; logic l; } beat_t;
  typedef struct { logic [1:0] e; bit mm; } st_t;

  beat_t        exp_beat_q[$];
  logic [31:0]  exp_meta_q[$];
  logic [63:0]  exp_done_q[$];
  st_t          st_plan_q[$];
  logic [63:0]  st_pend_q[$];
  logic [511:0] src_q[$];
  int           plan[$];
  bit           plan_mm = 0;

  int n_cmp = 0, n_bad = 0, cyc = 0, src_pops = 0, beat_num = 0;
  int cmd_acc_cyc = 0, done_rise_cyc = 0, cmd_pops0 = 0;
  int meta_rise_q[$], st_acc_q[$], st_pops_q[$], last_pos_q[$];
  logic [31:0] last_meta = '0;
  logic [63:0] last_keep = '0, last_done = '0;
  logic [31:0] exp_retry = 0, exp_drop = 0, exp_mm = 0;
  bit throttle = 0;
  bit cmd_fire = 0, meta_fire = 0, st_fire = 0, src_fire = 0, done_fire = 0;
  bit meta_v_d = 0, done_v_d = 0;

  beat_t       mb;
  st_t         ms;
  logic [31:0] mm_meta;
  logic [63:0] mm_done;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitors: handshakes are sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rstn) begin
      cmd_fire = 0; meta_fire = 0; st_fire = 0; src_fire = 0; done_fire = 0;
      meta_v_d = 0; done_v_d = 0;
    end else begin
      cmd_fire  = s_cmd_valid && s_cmd_ready;
      meta_fire = m_meta_valid && m_meta_ready;
      st_fire   = s_status_valid && s_status_ready;
      src_fire  = s_data_valid && s_data_ready;
      done_fire = m_done_valid && m_done_ready;
      if (cmd_fire) cmd_acc_cyc = cyc;
      if (m_meta_valid && !meta_v_d) meta_rise_q.push_back(cyc);
      meta_v_d = m_meta_valid;
      if (m_done_valid && !done_v_d) done_rise_cyc = cyc;
      done_v_d = m_done_valid;
      if (meta_fire) begin
        chk("meta_expected", exp_meta_q.size() != 0, 1);
        if (exp_meta_q.size() != 0) begin
          mm_meta = exp_meta_q.pop_front();
          chk("meta", m_meta_data, mm_meta);
        end
        last_meta = m_meta_data;
        ms.e = 2'd0; ms.mm = 0;
        if (st_plan_q.size() != 0) ms = st_plan_q.pop_front();
        st_pend_q.push_back({ms.e, 30'd4096, m_meta_data[31:16], m_meta_data[15:0] ^ {15'b0, ms.mm}});
      end
      if (st_fire) begin
        st_acc_q.push_back(cyc);
        st_pops_q.push_back(src_pops);
      end
      if (m_data_valid) chk("beat_expected", exp_beat_q.size() != 0, 1);
      if (m_data_valid && m_data_ready && exp_beat_q.size() != 0) begin
        mb = exp_beat_q.pop_front();
        beat_num++;
        chk("beat_data", m_data_data, mb.d);
        chk("beat_keep", m_data_keep, mb.k);
        chk("beat_last", m_data_last, mb.l);
        if (m_data_last) begin
          last_pos_q.push_back(beat_num);
          last_keep = m_data_keep;
        end
      end
      if (done_fire) begin
        chk("done_expected", exp_done_q.size() != 0, 1);
        if (exp_done_q.size() != 0) begin
          mm_done = exp_done_q.pop_front();
          chk("done", m_done_data, mm_done);
        end
        last_done = m_done_data;
      end
    end
  end

  // Sink readiness.
  initial forever begin
    @(posedge clk); #1;
    m_data_ready = !throttle || ($urandom_range(0, 3) != 0);
    m_meta_ready = !throttle || ($urandom_range(0, 2) != 0);
    m_done_ready = !throttle || ($urandom_range(0, 1) != 0);
  end

  // App payload source.
  initial forever begin
    @(posedge clk); #1;
    if (src_fire) begin
      void'(src_q.pop_front());
      src_pops++;
    end
    if (!(s_data_valid && !src_fire))
      s_data_valid = (src_q.size() != 0) && (!throttle || ($urandom_range(0, 3) != 0));
    if (src_q.size() != 0) s_data_data = src_q[0];
  end

  // Stack status responder: one status per accepted meta.
  initial forever begin
    @(posedge clk); #1;
    if (st_fire) s_status_valid = 1'b0;
    if (!s_status_valid && st_pend_q.size() != 0) begin
      s_status_data  = st_pend_q.pop_front();
      s_status_valid = 1'b1;
    end
  end

  task automatic start_cmd(input logic [15:0] sess, input logic [31:0] total);
    logic [31:0]  rem, sent, seg;
    logic [1:0]   e, err;
    logic [511:0] d;
    logic [511:0] beats[$];
    beat_t        b;
    st_t          s;
    int           pi, idx, nb, nbs;
    bit           fired;
    meta_rise_q.delete(); st_acc_q.delete(); st_pops_q.delete(); last_pos_q.delete();
    beat_num = 0;
    cmd_pops0 = src_pops;
    nb = int'((total + 32'd63) / 32'd64);
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < 16; j++) d[j*32 +: 32] = $urandom;
      beats.push_back(d);
      src_q.push_back(d);
    end
    rem = total; sent = 0; err = 0; pi = 0; idx = 0;
    while (rem != 0 && err == 0) begin
      seg = (rem < MAXB) ? rem : MAXB;
      do begin
        e = (pi < plan.size()) ? 2'(plan[pi]) : 2'd0;
        s.e = e;
        s.mm = plan_mm && (pi == 0);
        if (s.mm) exp_mm++;
        if (e == 2'd2) exp_retry++;
        pi++;
        exp_meta_q.push_back({seg[15:0], sess});
        st_plan_q.push_back(s);
      end while (e == 2'd2);
      if (e == 2'd0) begin
        nbs = int'((seg + 32'd63) / 32'd64);
        for (int bi = 0; bi < nbs; bi++) begin
          b.d = beats[idx];
          idx++;
          b.l = (bi == nbs - 1);
          b.k = '1;
          if (b.l && (seg % 64) != 0) b.k = (64'd1 << (seg % 64)) - 64'd1;
          exp_beat_q.push_back(b);
        end
        sent += seg;
        rem  -= seg;
      end else begin
        err = e;
        exp_drop++;
      end
    end
    exp_done_q.push_back({14'b0, err, sent, sess});
    plan.delete();
    plan_mm = 0;
    s_cmd_data  = {total, sess};
    s_cmd_valid = 1'b1;
    fired = 0;
    for (int i = 0; i < 1000 && !fired; i++) begin
      @(posedge clk); #1;
      fired = cmd_fire;
    end
    s_cmd_valid = 1'b0;
    chk("cmd_accepted", fired, 1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && exp_done_q.size() != 0; i++) @(posedge clk);
    chk("done_seen", exp_done_q.size(), 0);
    chk("meta_left", exp_meta_q.size(), 0);
    chk("beat_left", exp_beat_q.size(), 0);
    @(posedge clk); #1;
    chk("src_left", src_q.size(), 0);
    chk("retry_cnt", retry_cnt, exp_retry);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("mismatch_cnt", mismatch_cnt, exp_mm);
    exp_done_q.delete(); exp_meta_q.delete(); exp_beat_q.delete();
    st_plan_q.delete(); src_q.delete();
  endtask

  task automatic chk_reset(input string ph);
    chk({ph, "_cmd_ready"}, s_cmd_ready, 0);
    chk({ph, "_meta_valid"}, m_meta_valid, 0);
    chk({ph, "_meta_data"}, m_meta_data, 0);
    chk({ph, "_status_ready"}, s_status_ready, 0);
    chk({ph, "_data_ready"}, s_data_ready, 0);
    chk({ph, "_data_valid"}, m_data_valid, 0);
    chk({ph, "_keep"}, m_data_keep, 0);
    chk({ph, "_last"}, m_data_last, 0);
    chk({ph, "_done_valid"}, m_done_valid, 0);
    chk({ph, "_done_data"}, m_done_data, 0);
    chk({ph, "_counters"}, {retry_cnt, drop_cnt, mismatch_cnt}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    @(posedge clk); #1;
    rstn = 1'b1;

    // 100 B, status ok
    start_cmd(16'h0005, 32'd100);
    wait_done();
    chk("t1_meta", last_meta, 32'h0064_0005);
    chk("t1_keep", last_keep, 64'h0000_000F_FFFF_FFFF);
    chk("t1_done", last_done, 64'h0000_0000_0064_0005);
    if (meta_rise_q.size() != 0) chk("t1_meta_lat", meta_rise_q[0] - cmd_acc_cyc, 1);

    // 3000 B, three segments
    start_cmd(16'h0011, 32'd3000);
    wait_done();
    chk("t2_nlast", last_pos_q.size(), 3);
    if (last_pos_q.size() == 3) begin
      chk("t2_last0", last_pos_q[0], 22);
      chk("t2_last1", last_pos_q[1], 44);
      chk("t2_last2", last_pos_q[2], 47);
    end
    chk("t2_keep", last_keep, 64'h00FF_FFFF_FFFF_FFFF);
    chk("t2_done", last_done, {14'b0, 2'd0, 32'd3000, 16'h0011});

    // no space, then ok
    plan.push_back(2); plan.push_back(0);
    start_cmd(16'h0007, 32'd100);
    wait_done();
    chk("t3_nmeta", meta_rise_q.size(), 2);
    chk("t3_nstat", st_acc_q.size(), 2);
    if (meta_rise_q.size() == 2 && st_acc_q.size() == 2) begin
      chk("t3_retry_lat", meta_rise_q[1] - st_acc_q[0], RD + 1);
      chk("t3_nodata", st_pops_q[1], cmd_pops0);
    end
    chk("t3_retry", retry_cnt, 1);

    // second segment dropped
    plan.push_back(0); plan.push_back(1);
    start_cmd(16'h0021, 32'd3000);
    wait_done();
    chk("t4_done", last_done, {14'b0, 2'd1, 32'd1408, 16'h0021});
    chk("t4_drop", drop_cnt, 1);
    chk("t4_fwd", beat_num, 22);
    chk("t4_consumed", src_pops - cmd_pops0, 47);

    // zero length
    start_cmd(16'h0033, 32'd0);
    wait_done();
    chk("t5_nmeta", meta_rise_q.size(), 0);
    chk("t5_done_lat", done_rise_cyc - cmd_acc_cyc, 1);
    chk("t5_done", last_done, {48'd0, 16'h0033});

    // throttled random commands
    throttle = 1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) plan_mm = 1;
      if (k % 3 == 1) plan.push_back(2);
      if (k == 7) begin plan.push_back(0); plan.push_back(3); end
      start_cmd(16'(16'h0100 + k), 32'($urandom_range(1, 5000)));
      wait_done();
    end
    throttle = 0;

    // reset mid-DATA
    start_cmd(16'h0044, 32'd3000);
    for (int i = 0; i < 2000 && beat_num < 5; i++) @(posedge clk);
    chk("t7_in_data", beat_num >= 5, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_reset("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
